// File: rtl/io_hub.sv
// Memory-mapped I/O hub: decodes an internal register bank (LEDs, debounced
// buttons, frame counter, cycle timer) and forwards a VGA pixel write window.
module io_hub #(
  parameter logic [31:0] IO_BASE         = 32'h0002_0000,
  parameter logic [31:0] VGA_BASE        = 32'h0001_0000,
  parameter logic [31:0] VGA_SPAN        = 32'h0001_0000,
  parameter int          NUM_BTNS        = 5,
  parameter int          NUM_LEDS        = 16,
  parameter int          DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         bus_addr,
  input  logic [31:0]         bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [31:0]         bus_rdata,
  input  logic [NUM_BTNS-1:0] btns,
  output logic [NUM_LEDS-1:0] led,
  input  logic                frame_trig,
  output logic                vga_we,
  output logic [31:0]         vga_offset
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [9:0] OFS_LED       = 10'h000;
  localparam logic [9:0] OFS_BTN_LEVEL = 10'h001;
  localparam logic [9:0] OFS_BTN_EDGE  = 10'h002;
  localparam logic [9:0] OFS_FRAME_CNT = 10'h003;
  localparam logic [9:0] OFS_CYCLES    = 10'h004;

  logic                io_sel, vga_sel, wr_hit, rd_hit;
  logic [9:0]          reg_idx;
  logic [NUM_LEDS-1:0] led_reg;
  logic [NUM_BTNS-1:0] btn_sync1, btn_sync2, btn_level, btn_edge;
  logic [NUM_BTNS-1:0] btn_flip, btn_rise, edge_clr;
  logic [CNT_W-1:0]    db_cnt [NUM_BTNS];
  logic                frame_prev, frame_edge;
  logic [31:0]         frame_cnt, cycles, rd_mux;

  // Widen to 33 bits so a window ending at the top of the address space
  // does not wrap the upper bound to zero.
  assign io_sel  = (bus_addr[31:12] == IO_BASE[31:12]);
  assign vga_sel = (bus_addr >= VGA_BASE) &&
                   ({1'b0, bus_addr} < ({1'b0, VGA_BASE} + {1'b0, VGA_SPAN}));
  assign reg_idx = bus_addr[11:2];
  assign wr_hit  = bus_we & io_sel;
  assign rd_hit  = bus_re & io_sel;

  assign vga_we     = bus_we & vga_sel;
  assign vga_offset = bus_addr - VGA_BASE;
  assign led        = led_reg;

  // A bit flips when its counter has run out while the input still disagrees.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    btn_flip = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      btn_flip[i] = (btn_sync2[i] != btn_level[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  assign btn_rise   = btn_flip & ~btn_level;
  assign edge_clr   = ({NUM_BTNS{rd_hit && (reg_idx == OFS_BTN_EDGE)}}) |
                      ({NUM_BTNS{wr_hit && (reg_idx == OFS_BTN_EDGE)}} &
                       bus_wdata[NUM_BTNS-1:0]);
  assign frame_edge = frame_trig & ~frame_prev;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, which is what gives reads their pre-update semantics.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
      btn_level <= '0;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt[i] <= '0;
    end else begin
      btn_sync1 <= btns;
      btn_sync2 <= btn_sync1;
      btn_level <= btn_level ^ btn_flip;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (btn_sync2[i] == btn_level[i] || btn_flip[i]) db_cnt[i] <= '0;
        else                                             db_cnt[i] <= db_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Set wins over clear so an edge landing on a read or W1C is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg    <= '0;
      btn_edge   <= '0;
      frame_prev <= 1'b0;
      frame_cnt  <= '0;
      cycles     <= '0;
    end else begin
      if (wr_hit && reg_idx == OFS_LED) led_reg <= bus_wdata[NUM_LEDS-1:0];
      btn_edge   <= (btn_edge & ~edge_clr) | btn_rise;
      frame_prev <= frame_trig;
      if (wr_hit && reg_idx == OFS_FRAME_CNT) frame_cnt <= frame_edge ? 32'd1 : 32'd0;
      else if (frame_edge)                    frame_cnt <= frame_cnt + 32'd1;
      if (wr_hit && reg_idx == OFS_CYCLES) cycles <= bus_wdata;
      else                                 cycles <= cycles + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      OFS_LED:       rd_mux[NUM_LEDS-1:0] = led_reg;
      OFS_BTN_LEVEL: rd_mux[NUM_BTNS-1:0] = btn_level;
      OFS_BTN_EDGE:  rd_mux[NUM_BTNS-1:0] = btn_edge;
      OFS_FRAME_CNT: rd_mux               = frame_cnt;
      OFS_CYCLES:    rd_mux               = cycles;
      default:       rd_mux               = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         bus_rdata <= '0;
    else if (bus_re) bus_rdata <= io_sel ? rd_mux : 32'd0;
  end

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: reads are scored against a queue of
// expected values pushed when each read is issued.
module tb_io_hub;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, vga_offset;
  logic        bus_we, bus_re, frame_trig, vga_we;
  logic [4:0]  btns;
  logic [15:0] led;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] A_LED   = 32'h0002_0000;
  localparam logic [31:0] A_LEVEL = 32'h0002_0004;
  localparam logic [31:0] A_EDGE  = 32'h0002_0008;
  localparam logic [31:0] A_FRAME = 32'h0002_000C;
  localparam logic [31:0] A_CYC   = 32'h0002_0010;

  io_hub #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .btns       (btns),
    .led        (led),
    .frame_trig (frame_trig),
    .vga_we     (vga_we),
    .vga_offset (vga_offset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle driven at a negedge; a read's result is scored one edge later.
  task automatic bus_cycle(input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    bus_we = we; bus_re = re; bus_addr = addr; bus_wdata = wdata;
    if (re) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    if (re) begin
      if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else check(tag_q.pop_front(), bus_rdata, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_cycle(1'b1, 1'b0, addr, data, 32'd0, "wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus_cycle(1'b0, 1'b1, addr, 32'd0, exp, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    frame_trig = 1'b1;
    @(negedge clk);
    frame_trig = 1'b0;
    @(negedge clk);
  endtask

  task automatic vga_probe(input logic we, input logic [31:0] addr, input logic exp_we,
                           input logic [31:0] exp_off, input string tag);
    bus_we = we; bus_addr = addr; bus_wdata = 32'd0;
    #1;
    check(tag, 32'(vga_we), 32'(exp_we));
    if (exp_we) check({tag, "_off"}, vga_offset, exp_off);
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    btns = '0; frame_trig = 1'b0;
    idle(2);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_vga_we", 32'(vga_we), 32'd0);
    rst = 1'b0;
    rd(A_CYC, 32'd0, "cyc_after_rst");

    // LED register
    wr(A_LED, 32'h0000_A5A5);
    check("led_out", 32'(led), 32'h0000_A5A5);
    rd(A_LED, 32'h0000_A5A5, "led_rd");
    check("rdata_hold", bus_rdata, 32'h0000_A5A5);
    wr(A_LEVEL, 32'hFFFF_FFFF);
    rd(A_LEVEL, 32'd0, "level_ro");
    rd(32'h0002_0003, 32'h0000_A5A5, "led_lowbits");
    rd(32'h0002_0020, 32'd0, "unmapped");
    rd(32'h0003_0000, 32'd0, "outside_io");
    wr(A_LED, 32'hFFFF_5A5A);
    rd(A_LED, 32'h0000_5A5A, "led_upper0");
    bus_cycle(1'b1, 1'b1, A_LED, 32'h0000_1111, 32'h0000_5A5A, "led_rw_pre");
    check("led_rw_post", 32'(led), 32'h0000_1111);

    // Debounce: level changes exactly 6 edges after the raw input
    btns[2] = 1'b1;
    idle(5);
    rd(A_LEVEL, 32'd0, "level_edge6_pre");
    rd(A_LEVEL, 32'h4, "level_b2");
    rd(A_EDGE, 32'h4, "edge_b2");
    rd(A_EDGE, 32'd0, "edge_rc");
    btns[0] = 1'b1;
    idle(3);
    btns[0] = 1'b0;
    idle(10);
    rd(A_LEVEL, 32'h4, "glitch_level");
    rd(A_EDGE, 32'd0, "glitch_edge");

    // Edge lands on the same edge as a read-clear
    btns[1] = 1'b1;
    idle(5);
    rd(A_EDGE, 32'd0, "coll_rd");
    rd(A_LEVEL, 32'h6, "coll_level");
    rd(A_EDGE, 32'h2, "coll_kept");
    rd(A_EDGE, 32'd0, "coll_cleared");

    // W1C on set and unset bits
    btns[3] = 1'b1;
    idle(10);
    wr(A_EDGE, 32'h8);
    rd(A_EDGE, 32'd0, "w1c_clear");
    btns[4] = 1'b1;
    idle(10);
    wr(A_EDGE, 32'h1);
    rd(A_EDGE, 32'h10, "w1c_other");
    btns[2] = 1'b0;
    idle(10);
    rd(A_LEVEL, 32'h1A, "fall_level");
    rd(A_EDGE, 32'd0, "fall_no_edge");

    // Frame counter
    repeat (3) pulse();
    rd(A_FRAME, 32'd3, "frame3");
    wr(A_FRAME, 32'hDEAD_BEEF);
    rd(A_FRAME, 32'd0, "frame_wclr");
    frame_trig = 1'b1;
    wr(A_FRAME, 32'd0);
    frame_trig = 1'b0;
    idle(1);
    rd(A_FRAME, 32'd1, "frame_wclr_edge");
    frame_trig = 1'b1;
    rd(A_FRAME, 32'd1, "frame_rd_pre");
    idle(3);
    frame_trig = 1'b0;
    rd(A_FRAME, 32'd2, "frame_long");
    force dut.frame_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_cnt;
    pulse();
    rd(A_FRAME, 32'd0, "frame_wrap");

    // Cycle timer load and wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC, 32'hFFFF_FFFE, "cyc_load");
    rd(A_CYC, 32'hFFFF_FFFF, "cyc_inc");
    rd(A_CYC, 32'd0, "cyc_wrap");

    // VGA window
    vga_probe(1'b1, 32'h0001_0124, 1'b1, 32'h0000_0124, "vga_in");
    vga_probe(1'b1, 32'h0001_FFFC, 1'b1, 32'h0000_FFFC, "vga_top");
    vga_probe(1'b1, 32'h0000_FFFC, 1'b0, 32'd0, "vga_below");
    vga_probe(1'b1, 32'h0002_0000, 1'b0, 32'd0, "vga_above");
    check("vga_led_wr", 32'(led), 32'd0);
    vga_probe(1'b0, 32'h0001_0124, 1'b0, 32'd0, "vga_no_we");

    // Reset mid-debounce and mid-count
    wr(A_LED, 32'h0000_BEEF);
    btns[0] = 1'b1;
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_rdata", bus_rdata, 32'd0);
    rd(A_LEVEL, 32'd0, "mid_rst_level");
    rd(A_FRAME, 32'd0, "mid_rst_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
